seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 193 +++++++++++++++++++
 tb/tb_seq_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern generator: sends an MSB-first bit pattern a programmable number
// of times with optional idle gaps between repetitions, reporting busy/done/err.
module seq_gen #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [4:0]         len,
  input  logic [3:0]         reps,
  input  logic [3:0]         gap,
  output logic               x,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

  function automatic logic pick_bit(input logic [31:0] vec, input logic [4:0] idx);
    pick_bit = vec[idx];
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MAX_LEN-1:0]   r_pat;
  logic [MAX_LEN-1:0]   w_pat_nxt;
  logic [4:0]           r_len;
  logic [4:0]           w_len_nxt;
  logic [3:0]           r_rep;
  logic [3:0]           w_rep_nxt;
  logic [3:0]           r_gap;
  logic [3:0]           w_gap_nxt;
  logic [4:0]           r_bit;
  logic [4:0]           w_bit_nxt;
  logic [3:0]           r_gcnt;
  logic [3:0]           w_gcnt_nxt;
  logic                 r_x;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 w_x_nxt;
  logic                 w_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_len_ok;
  logic [4:0]           w_len_m1;
  logic [4:0]           w_rlen_m1;
  logic [4:0]           w_bit_m1;
  logic [3:0]           w_reps_m1;

  assign w_len_ok  = (len != 5'd0) && ({1'b0, len} <= LEN_MAX);
  assign w_len_m1  = len - 5'd1;
  assign w_rlen_m1 = r_len - 5'd1;
  assign w_bit_m1  = r_bit - 5'd1;
  // r_rep holds the repetitions still owed after the current one, so reps=0 and 1 both give 0
  assign w_reps_m1 = (reps == 4'd0) ? 4'd0 : (reps - 4'd1);

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_rep_nxt   = r_rep;
    w_gap_nxt   = r_gap;
    w_bit_nxt   = r_bit;
    w_gcnt_nxt  = r_gcnt;
    w_x_nxt     = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      IDLE, FIN: begin
        if (start) begin
          if (w_len_ok) begin
            w_state_nxt = SEND;
            w_pat_nxt   = pattern;
            w_len_nxt   = len;
            w_rep_nxt   = w_reps_m1;
            w_gap_nxt   = gap;
            w_bit_nxt   = w_len_m1;
            w_gcnt_nxt  = 4'd0;
            w_x_nxt     = pick_bit(32'(pattern), w_len_m1);
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      SEND: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_bit != 5'd0) begin
          w_bit_nxt   = w_bit_m1;
          w_x_nxt     = pick_bit(32'(r_pat), w_bit_m1);
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (r_rep != 4'd0) begin
          w_rep_nxt  = r_rep - 4'd1;
          w_busy_nxt = 1'b1;
          if (r_gap != 4'd0) begin
            w_state_nxt = GAP;
            w_gcnt_nxt  = r_gap - 4'd1;
          end else begin
            w_bit_nxt   = w_rlen_m1;
            w_x_nxt     = pick_bit(32'(r_pat), w_rlen_m1);
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = FIN;
          w_done_nxt  = 1'b1;
        end
      end

      GAP: begin
        // r_gcnt counts the gap cycles still to follow the current one
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_gcnt != 4'd0) begin
          w_gcnt_nxt = r_gcnt - 4'd1;
          w_busy_nxt = 1'b1;
        end else begin
          w_state_nxt = SEND;
          w_bit_nxt   = w_rlen_m1;
          w_x_nxt     = pick_bit(32'(r_pat), w_rlen_m1);
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched parameters, counters and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= 5'd0;
      r_rep   <= 4'd0;
      r_gap   <= 4'd0;
      r_bit   <= 5'd0;
      r_gcnt  <= 4'd0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_rep   <= w_rep_nxt;
      r_gap   <= w_gap_nxt;
      r_bit   <= w_bit_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_x     <= w_x_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign x     = r_x;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected {busy,valid,x,done,err} per cycle is
// queued when a frame is requested and compared after every rising edge.
module tb_seq_gen;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  reps;
  logic [3:0]  gap;
  logic        x;
  logic        valid;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks;
  int          n_errors;
  string       cur_tag;
  logic [4:0]  exp_q[$];

  seq_gen #(.MAX_LEN(16)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .gap     (gap),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expd);
    n_checks++;
    if (got !== expd) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expd);
    end
  endtask

  // Expected outputs of a whole frame, derived from the currently applied inputs
  task automatic push_frame();
    int re;
    re = (reps == 4'd0) ? 1 : int'(reps);
    for (int r = 0; r < re; r++) begin
      for (int b = int'(len) - 1; b >= 0; b--) exp_q.push_back({2'b11, pattern[b], 2'b00});
      if (r < re - 1) begin
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(5'b10000);
      end
    end
    exp_q.push_back(5'b00010);
  endtask

  // Called just after a falling edge: drive inputs, update scoreboard, check the next edge
  task automatic tick(input logic st, input logic ab);
    logic [4:0] expd;
    start = st;
    abort = ab;
    if (ab && exp_q.size() > 0) begin
      exp_q.delete();
    end else if (st && exp_q.size() == 0) begin
      if (len != 5'd0 && len <= 5'd16) push_frame();
      else exp_q.push_back(5'b00001);
    end
    @(negedge clk);
    expd = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
    check_val(cur_tag, {27'd0, busy, valid, x, done, err}, {27'd0, expd});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check_val({cur_tag, " timeout"}, exp_q.size(), 0);
  endtask

  task automatic set_in(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r, input logic [3:0] g);
    pattern = p;
    len     = l;
    reps    = r;
    gap     = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_in(16'h0000, 5'd0, 4'd0, 4'd0);
    #3;
    check_val("reset", {27'd0, busy, valid, x, done, err}, 32'd0);
    #9 clr_n = 1'b1;
    @(negedge clk);

    cur_tag = "basic6";
    set_in(16'b101010, 5'd6, 4'd1, 4'd0);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "rep2gap2";
    set_in(16'b101, 5'd3, 4'd2, 4'd2);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "len0";
    set_in(16'hFFFF, 5'd0, 4'd1, 4'd0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cur_tag = "len17";
    set_in(16'hFFFF, 5'd17, 4'd1, 4'd0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    cur_tag = "abort";
    set_in(16'hA5C3, 5'd16, 4'd4, 4'd1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    cur_tag = "after_abort";
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "reset_gap";
    set_in(16'b110, 5'd3, 4'd2, 4'd3);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    #2 clr_n = 1'b0;
    #1 check_val("reset_async", {27'd0, busy, valid, x, done, err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    clr_n = 1'b1;
    cur_tag = "post_reset";
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

    cur_tag = "midframe";
    set_in(16'h00C5, 5'd8, 4'd2, 4'd1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    set_in(16'hFFFF, 5'd5, 4'd7, 4'd0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    drain();
    cur_tag = "fin_start";
    set_in(16'h0002, 5'd2, 4'd3, 4'd0);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "reps0";
    set_in(16'b10, 5'd2, 4'd0, 4'd5);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "max15";
    set_in(16'h0001, 5'd1, 4'd15, 4'd15);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    cur_tag = "len16";
    set_in(16'h8001, 5'd16, 4'd1, 4'd0);
    tick(1'b1, 1'b0);
    drain();
    tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
